// File: rtl/sl_ahb_sram_ctrl.sv
// AHB-Lite slave driving one 32-bit SRAM; zero-wait reads, single-entry write buffer when SL_AHB_SRAM_WBUF_EN is defined.
// Without the buffer, a read address phase during a write data phase costs one HREADYOUT=0 cycle.
module sl_ahb_sram_ctrl #(
    parameter int AW = 16
) (
    input  logic          HCLK,
    input  logic          HRESETn,
    input  logic          HSEL,
    input  logic [AW-1:0] HADDR,
    input  logic [1:0]    HTRANS,
    input  logic [2:0]    HSIZE,
    input  logic          HWRITE,
    input  logic [31:0]   HWDATA,
    input  logic          HREADY,
    output logic          HREADYOUT,
    output logic [31:0]   HRDATA,
    output logic          HRESP,
    output logic [AW-3:0] SRAM_ADDR,
    output logic [31:0]   SRAM_WDATA,
    output logic [3:0]    SRAM_WREN,
    output logic          SRAM_CS,
    input  logic [31:0]   SRAM_RDATA
);

    logic          valid, rd_ap, wr_ap, direct_wr;
    logic          wr_dph, rd_dph;
    logic [AW-3:0] wr_addr_q, rd_addr_q;
    logic [3:0]    wr_strb_q, strb;
    logic [31:0]   rdata_merged;

    assign valid = HSEL & HREADY & HTRANS[1];
    assign rd_ap = valid & ~HWRITE;
    assign wr_ap = valid & HWRITE;
    assign HRESP = 1'b0;

    always_comb begin
        strb = 4'b1111;
        if (HSIZE == 3'd0)
            strb = 4'b0001 << HADDR[1:0];
        else if (HSIZE == 3'd1)
            strb = HADDR[1] ? 4'b1100 : 4'b0011;
    end

    // Phase flags only advance when the bus completes a cycle (extended data phases hold them).
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            wr_dph    <= 1'b0;
            rd_dph    <= 1'b0;
            wr_addr_q <= '0;
            rd_addr_q <= '0;
            wr_strb_q <= '0;
        end else if (HREADY) begin
            wr_dph <= wr_ap;
            rd_dph <= rd_ap;
            if (wr_ap) begin
                wr_addr_q <= HADDR[AW-1:2];
                wr_strb_q <= strb;
            end
            if (rd_ap)
                rd_addr_q <= HADDR[AW-1:2];
        end
    end

`ifdef SL_AHB_SRAM_WBUF_EN
    logic          buf_vld, buf_load, drain;
    logic [AW-3:0] buf_addr;
    logic [3:0]    buf_strb;
    logic [31:0]   buf_dat;

    assign direct_wr = wr_dph & ~rd_ap;
    assign buf_load  = wr_dph & rd_ap;
    assign drain     = buf_vld & ~rd_ap & ~direct_wr;
    assign HREADYOUT = 1'b1;

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            buf_vld  <= 1'b0;
            buf_addr <= '0;
            buf_strb <= '0;
            buf_dat  <= '0;
        end else if (buf_load) begin
            buf_vld  <= 1'b1;
            buf_addr <= wr_addr_q;
            buf_strb <= wr_strb_q;
            buf_dat  <= HWDATA;
        end else if (drain) begin
            buf_vld  <= 1'b0;
        end
    end

    // Merge uses only registered buffer state, so HWDATA never reaches HRDATA combinationally.
    always_comb begin
        rdata_merged = SRAM_RDATA;
        for (int b = 0; b < 4; b++)
            if (buf_vld && buf_addr == rd_addr_q && buf_strb[b])
                rdata_merged[8*b +: 8] = buf_dat[8*b +: 8];
    end
`else
    logic stall, wr_done;

    assign stall        = wr_dph & ~wr_done & HSEL & HTRANS[1] & ~HWRITE;
    assign direct_wr    = wr_dph & ~wr_done;
    assign rdata_merged = SRAM_RDATA;
    assign HREADYOUT    = ~HRESETn | ~stall;

    // One-shot: the stalled write is performed once and the stall lasts a single cycle.
    always_ff @(posedge HCLK) begin
        if (!HRESETn)
            wr_done <= 1'b0;
        else
            wr_done <= stall;
    end
`endif

    always_comb begin
        SRAM_CS    = 1'b0;
        SRAM_WREN  = 4'b0000;
        SRAM_ADDR  = HADDR[AW-1:2];
        SRAM_WDATA = HWDATA;
        if (HRESETn) begin
            if (rd_ap) begin
                SRAM_CS = 1'b1;
            end else if (direct_wr) begin
                SRAM_CS   = 1'b1;
                SRAM_WREN = wr_strb_q;
                SRAM_ADDR = wr_addr_q;
            end
`ifdef SL_AHB_SRAM_WBUF_EN
            else if (drain) begin
                SRAM_CS    = 1'b1;
                SRAM_WREN  = buf_strb;
                SRAM_ADDR  = buf_addr;
                SRAM_WDATA = buf_dat;
            end
`endif
        end
    end

    always_comb begin
        HRDATA = 32'h0;
        if (HRESETn && rd_dph)
            HRDATA = rdata_merged;
    end

endmodule

// File: tb/tb_sl_ahb_sram_ctrl.sv
// Bench for sl_ahb_sram_ctrl: directed op table plus random traffic checked against a bus-order memory model.
module tb_sl_ahb_sram_ctrl;
    localparam int AW = 16;

    logic        HCLK = 1'b0;
    logic        HRESETn, HSEL, HWRITE, HREADY, HREADYOUT, HRESP, SRAM_CS;
    logic [15:0] HADDR;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE;
    logic [31:0] HWDATA, HRDATA, SRAM_WDATA, SRAM_RDATA;
    logic [13:0] SRAM_ADDR;
    logic [3:0]  SRAM_WREN;

    always #5 HCLK = ~HCLK;
    assign HREADY = HREADYOUT;

    sl_ahb_sram_ctrl #(.AW(AW)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
        .HSIZE(HSIZE), .HWRITE(HWRITE), .HWDATA(HWDATA), .HREADY(HREADY),
        .HREADYOUT(HREADYOUT), .HRDATA(HRDATA), .HRESP(HRESP), .SRAM_ADDR(SRAM_ADDR),
        .SRAM_WDATA(SRAM_WDATA), .SRAM_WREN(SRAM_WREN), .SRAM_CS(SRAM_CS), .SRAM_RDATA(SRAM_RDATA)
    );

    // SRAM macro behaviour: registered read, byte-lane writes.
    logic [31:0] mem [0:16383];
    logic [31:0] rdq = 32'h0;
    logic        saw_byte_wr = 1'b0;
    assign SRAM_RDATA = rdq;
    always @(posedge HCLK) begin
        if (SRAM_CS) begin
            if (SRAM_WREN == 4'b0000)
                rdq <= mem[SRAM_ADDR];
            else
                for (int b = 0; b < 4; b++)
                    if (SRAM_WREN[b]) mem[SRAM_ADDR][8*b +: 8] <= SRAM_WDATA[8*b +: 8];
            if (SRAM_WREN == 4'b0010 && SRAM_ADDR == 14'h000C)
                saw_byte_wr <= 1'b1;
        end
    end

    // Reference: memory as seen in bus order; a read returns everything issued before it.
    logic [31:0] ref_mem [0:16383];
    bit          pend_wr, pend_rd, pend_stalled;
    logic [31:0] pend_data, pend_exp;
    int          n_chk = 0, n_pass = 0;

    typedef struct {
        int          kind;   // 0 idle, 1 read, 2 write
        logic [15:0] addr;
        logic [2:0]  size;
        logic [31:0] data;
        logic [31:0] exp;
        bit          has_exp;
    } op_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic ref_write(input logic [15:0] a, input logic [2:0] sz, input logic [31:0] d);
        int nb, off;
        nb  = (sz == 3'd0) ? 1 : (sz == 3'd1) ? 2 : 4;
        off = (int'(a[1:0]) / nb) * nb;
        for (int b = 0; b < 4; b++)
            if (b >= off && b < off + nb) ref_mem[a[15:2]][8*b +: 8] = d[8*b +: 8];
    endtask

    task automatic do_op(input op_t o);
        bit accepted = 0;
        int guard = 0;
        bit exp_rdy;
        while (!accepted) begin
            @(posedge HCLK); #1;
            HWDATA = pend_wr ? pend_data : $urandom;
            if (o.kind == 0) begin
                if ($urandom_range(1) == 1) begin
                    HSEL = 1'b0; HTRANS = 2'($urandom_range(3));
                end else begin
                    HSEL = 1'b1; HTRANS = 2'($urandom_range(1));
                end
                HADDR = 16'($urandom); HWRITE = 1'($urandom_range(1)); HSIZE = 3'($urandom_range(7));
            end else begin
                HSEL = 1'b1; HTRANS = ($urandom_range(1) == 1) ? 2'b10 : 2'b11;
                HADDR = o.addr; HWRITE = (o.kind == 2); HSIZE = o.size;
            end
            @(negedge HCLK);
`ifdef SL_AHB_SRAM_WBUF_EN
            exp_rdy = 1'b1;
`else
            exp_rdy = !(pend_wr && !pend_stalled && o.kind == 1);
`endif
            check("hreadyout", {31'b0, HREADYOUT}, {31'b0, exp_rdy});
            check("hrdata", HRDATA, pend_rd ? pend_exp : 32'h0);
            if (HREADYOUT) begin
                pend_rd = (o.kind == 1);
                pend_wr = (o.kind == 2);
                pend_stalled = 1'b0;
                if (o.kind == 2) begin
                    pend_data = o.data;
                    ref_write(o.addr, o.size, o.data);
                end
                if (o.kind == 1) pend_exp = o.has_exp ? o.exp : ref_mem[o.addr[15:2]];
                accepted = 1;
            end else begin
                pend_stalled = 1'b1;
                pend_rd = 1'b0;
                guard++;
                if (guard > 4) begin
                    n_chk++;
                    $display("FAIL stall_timeout: HREADYOUT still 0 after %0d cycles, required 1", guard);
                    accepted = 1;
                end
            end
        end
    endtask

    function automatic op_t mk(input int k, input logic [15:0] a, input logic [2:0] s,
                               input logic [31:0] d, input logic [31:0] e, input bit he);
        op_t o;
        o.kind = k; o.addr = a; o.size = s; o.data = d; o.exp = e; o.has_exp = he;
        return o;
    endfunction

    op_t tbl[$];

    initial begin
        op_t r;
        logic [31:0] exp_discard;
        for (int i = 0; i < 16384; i++) begin mem[i] = 32'h0; ref_mem[i] = 32'h0; end
        pend_wr = 0; pend_rd = 0; pend_stalled = 0; pend_data = 0; pend_exp = 0;
        HRESETn = 1'b0; HSEL = 1'b0; HTRANS = 2'b00; HADDR = '0; HSIZE = 3'd2; HWRITE = 1'b0; HWDATA = '0;

        // Directed table: inputs plus expected read data.
        tbl.push_back(mk(2, 16'h0010, 3'd2, 32'hDEADBEEF, 0, 0));
        tbl.push_back(mk(0, 16'h0000, 3'd0, 0, 0, 0));
        tbl.push_back(mk(1, 16'h0010, 3'd2, 0, 32'hDEADBEEF, 1));
        tbl.push_back(mk(2, 16'h0020, 3'd2, 32'h11223344, 0, 0));
        tbl.push_back(mk(1, 16'h0020, 3'd2, 0, 32'h11223344, 1));
        tbl.push_back(mk(0, 16'h0000, 3'd0, 0, 0, 0));
        tbl.push_back(mk(2, 16'h0030, 3'd2, 32'h0, 0, 0));
        tbl.push_back(mk(0, 16'h0000, 3'd0, 0, 0, 0));
        tbl.push_back(mk(2, 16'h0031, 3'd0, 32'h0000AB00, 0, 0));
        tbl.push_back(mk(1, 16'h0030, 3'd2, 0, 32'h0000AB00, 1));
        tbl.push_back(mk(0, 16'h0000, 3'd0, 0, 0, 0));
        tbl.push_back(mk(2, 16'h0032, 3'd1, 32'h5A5A0000, 0, 0));
        tbl.push_back(mk(1, 16'h0030, 3'd2, 0, 32'h5A5AAB00, 1));
        tbl.push_back(mk(2, 16'h0033, 3'd0, 32'h77000000, 0, 0));
        tbl.push_back(mk(1, 16'h0030, 3'd2, 0, 32'h775AAB00, 1));
        tbl.push_back(mk(2, 16'h0100, 3'd2, 32'hA0A0A0A0, 0, 0));
        tbl.push_back(mk(1, 16'h0010, 3'd2, 0, 32'hDEADBEEF, 1));
        tbl.push_back(mk(1, 16'h0020, 3'd2, 0, 32'h11223344, 1));
        tbl.push_back(mk(2, 16'h0104, 3'd2, 32'hA3A3A3A3, 0, 0));
        tbl.push_back(mk(1, 16'h0100, 3'd2, 0, 32'hA0A0A0A0, 1));
        tbl.push_back(mk(1, 16'h0104, 3'd2, 0, 32'hA3A3A3A3, 1));
        tbl.push_back(mk(2, 16'h0040, 3'd2, 32'hCAFEF00D, 0, 0));
        tbl.push_back(mk(1, 16'h0040, 3'd2, 0, 32'hCAFEF00D, 1));
        tbl.push_back(mk(0, 16'h0000, 3'd0, 0, 0, 0));
        tbl.push_back(mk(0, 16'h0000, 3'd0, 0, 0, 0));

        // Reset state, with an active read request presented.
        repeat (2) @(posedge HCLK);
        #1 HSEL = 1'b1; HTRANS = 2'b10;
        @(negedge HCLK);
        check("rst_cs", {31'b0, SRAM_CS}, 32'h0);
        check("rst_wren", {28'b0, SRAM_WREN}, 32'h0);
        check("rst_hreadyout", {31'b0, HREADYOUT}, 32'h1);
        check("rst_hresp", {31'b0, HRESP}, 32'h0);
        check("rst_hrdata", HRDATA, 32'h0);

        // Write 0x50 then read 0x54; reset lands while that write may still be buffered.
        @(posedge HCLK); #1 HRESETn = 1'b1; HSEL = 1'b0; HTRANS = 2'b00;
        @(posedge HCLK); #1 HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 16'h0050; HSIZE = 3'd2;
        @(posedge HCLK); #1 HWDATA = 32'h12345678; HWRITE = 1'b0; HADDR = 16'h0054;
        @(negedge HCLK);
`ifdef SL_AHB_SRAM_WBUF_EN
        check("rstseq_rdy", {31'b0, HREADYOUT}, 32'h1);
        exp_discard = 32'h0;
`else
        check("rstseq_rdy", {31'b0, HREADYOUT}, 32'h0);
        exp_discard = 32'h12345678;
`endif
        for (int c = 0; c < 2; c++) begin
            @(posedge HCLK); #1 HRESETn = 1'b0;
            @(negedge HCLK);
            check("rstseq_cs", {31'b0, SRAM_CS}, 32'h0);
            check("rstseq_hreadyout", {31'b0, HREADYOUT}, 32'h1);
            check("rstseq_hrdata", HRDATA, 32'h0);
        end
        @(posedge HCLK); #1 HRESETn = 1'b1; HSEL = 1'b0; HTRANS = 2'b00;
        repeat (3) @(posedge HCLK);
        @(negedge HCLK);
        check("rst_discard_mem", mem[14'h0014], exp_discard);
        ref_mem[14'h0014] = exp_discard;

        foreach (tbl[i]) do_op(tbl[i]);
        check("byte_strobe_0010", {31'b0, saw_byte_wr}, 32'h1);

        // Random traffic over a few words to provoke buffer hazards.
        for (int i = 0; i < 300; i++) begin
            r.kind = (($urandom_range(9) < 2) ? 0 : ($urandom_range(1) == 1) ? 1 : 2);
            r.size = 3'($urandom_range(3));
            r.addr = 16'h0400 + 16'({$urandom_range(7), 2'b00});
            if (r.size == 3'd0) r.addr[1:0] = 2'($urandom_range(3));
            else if (r.size == 3'd1) r.addr[1] = 1'($urandom_range(1));
            r.data = $urandom;
            r.exp = 0;
            r.has_exp = 0;
            do_op(r);
        end
        r = mk(0, 16'h0000, 3'd0, 0, 0, 0);
        repeat (4) do_op(r);

        for (int w = 0; w < 16'h0110; w++)
            check($sformatf("mem[%0h]", w), mem[w], ref_mem[w]);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/sl_ahb_sram_ctrl.md
# sl_ahb_sram_ctrl

AHB-Lite slave controller that acts as the initiator on the `sl_sram` port (ADDR/WDATA/WREN/CS in, RDATA out). It drives one 32-bit SRAM macro from the processor bus. A single-entry write buffer lets back-to-back reads and writes run with zero wait states. It sits between the system bus matrix and each `sl_sram` instance in the ASIC and FPGA builds.

## Interface
- `AW`, 16: byte address width. The SRAM word address is `[AW-1:2]`.
- `HCLK` in 1: the single clock. It also clocks the SRAM.
- `HRESETn` in 1: synchronous, active-low reset, sampled on the rising edge of `HCLK`.
- `HSEL` in 1: slave select.
- `HADDR` in AW: byte address.
- `HTRANS` in 2: transfer type. A bit1 value of 1 means NONSEQ or SEQ.
- `HSIZE` in 3: transfer size. 0 = byte, 1 = half, 2 or more = word.
- `HWRITE` in 1: 1 = write.
- `HWDATA` in 32: write data, valid in the data phase.
- `HREADY` in 1: bus ready.
- `HREADYOUT` out 1: slave ready.
- `HRDATA` out 32: read data.
- `HRESP` out 1: always 0 (OKAY).
- `SRAM_ADDR` out AW-2: word address to the SRAM.
- `SRAM_WDATA` out 32: write data to the SRAM.
- `SRAM_WREN` out 4: byte write enables. 0 means a read.
- `SRAM_CS` out 1: SRAM access this cycle. The SRAM samples it on the next `HCLK` edge.
- `SRAM_RDATA` in 32: SRAM read data, valid the cycle after a read access.

## Operation
- A transfer is accepted ("valid") when `HSEL & HREADY & HTRANS[1]`.
- Byte strobes come from `HSIZE` and `HADDR[1:0]`:
  - byte: `1<<HADDR[1:0]`.
  - half: `4'b0011` or `4'b1100`, selected by `HADDR[1]`.
  - word: `4'b1111`.
- Read address phase:
  - SRAM access is combinational in the same cycle: `SRAM_CS=1`, `SRAM_WREN=0`, `SRAM_ADDR=HADDR[AW-1:2]`.
  - The word address is registered for the data phase.
- Write address phase: the word address and strobes are registered, and a write-data-phase flag is set.
- Write data phase:
  - If the same cycle has no read address phase, the write goes direct to the SRAM: `SRAM_CS=1`, `SRAM_WREN=strobes`, `SRAM_ADDR=registered addr`, `SRAM_WDATA=HWDATA`.
  - Otherwise address, strobes and `HWDATA` load the buffer at the cycle end, and `buf_valid=1`.
- Buffer drain:
  - The drain fires in any cycle with `buf_valid`, no read address phase, and no direct write.
  - It drives the SRAM with the buffer contents and clears `buf_valid` at the cycle end.
- SRAM port priority: read address phase, then direct write, then buffer drain.
  - A direct write and a drain never coincide: any write address phase drains the buffer before that write's data phase.
  - The buffer therefore never overflows.
- Read data phase:
  - `HRDATA = SRAM_RDATA`, with every byte lane replaced by the buffer byte when `buf_valid`, the buffer address equals the registered read address, and the buffer strobe for that lane is set.
  - `buf_valid` and the buffer contents are the registered values at the start of the cycle.
  - This covers a read issued in the same cycle as a same-address write's data phase.
- Outside a read data phase, `HRDATA = 0`.
- `HREADYOUT = 1` always, with the buffer compiled in.
- Reset, and any cycle with `HRESETn=0`:
  - `SRAM_CS=0`, `SRAM_WREN=0`, `HREADYOUT=1`, `HRESP=0`, `HRDATA=0`.
  - Buffer and phase flags cleared.
  - A buffered write pending at reset is discarded.

## Timing
- Read latency: data is on `HRDATA` in the cycle after the address phase, with zero wait states.
- Write: the SRAM is updated at the end of the data phase (direct), or at the end of the first non-read cycle after it (buffered).
- The controller has no combinational path from `HWDATA` to `HRDATA`. The merge uses registered buffer data only.
- Non-selected, IDLE and BUSY cycles do not start transfers. They are drain opportunities.

## Configuration
- `SL_AHB_SRAM_WBUF_EN` defined: the write buffer and read merge are present, with zero wait states everywhere.
- `SL_AHB_SRAM_WBUF_EN` undefined: there is no buffer. Writes always go direct in the data phase.
  - If the write data phase sees `HSEL & HTRANS[1] & !HWRITE` (raw, ungated by `HREADY`), `HREADYOUT=0` for exactly that cycle and the write is performed.
  - The next cycle has `HREADYOUT=1`, and the stalled read is then accepted.
  - A registered one-shot flag prevents a repeated write or a second stall.

## Test plan
- Reset: assert `HRESETn=0` for 2 cycles with a pending buffered write -> `SRAM_CS=0`, `HREADYOUT=1`, `HRDATA=0`, and that SRAM word is unchanged.
- Word write then read, with an idle cycle between: W 0x0010 = 0xDEADBEEF, idle, R 0x0010 -> `HRDATA=0xDEADBEEF` with no wait states. The SRAM is written in the W data phase.
- Back-to-back W 0x0020 = 0x11223344 then R 0x0020 (read address phase during the write data phase) -> the buffer is loaded and the read returns 0x11223344 via the merge. The drain happens on the next idle cycle.
- Byte/half strobes: memory at 0x0030 = 0, W byte 0x0031 = 0xAB, then an immediate R word 0x0030 -> `HRDATA=0x0000AB00`. The drain drives `SRAM_WREN=4'b0010`.
- Stream W0, R1, R2, W3, R4 at different addresses -> all complete with `HREADYOUT=1`. W0 drains in W3's address phase. The final SRAM contents are correct.
- Macro undefined: W 0x0040 then an immediate R 0x0040 -> one `HREADYOUT=0` cycle, then the read returns the written value.
